alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station for the integer ALU pipe. It holds dispatched ALU, branch and jump operations until all source operands and flags are available, snoops the register-file and flag writeback buses, and issues one operation per cycle, oldest ready first, into the combinational `alu` execution unit. It is the initiator side of the `alu` input interface and consumes the same `*_W`/`*_RR` broadcast format that `alu` produces.

## Interface
- `DEPTH`, 8: number of entries. Power of two, minimum 2.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous kill of all entries and of the issue register. Driven by mispredict recovery.
- `disp_valid` input 1: dispatch request.
- `disp_opcode[3:0]`, `disp_imm[15:0]`, `disp_neg_opr2`, `disp_CZ_cond[1:0]`, `disp_dest[6:0]`, `disp_arch_dest[2:0]`, `disp_PC[15:0]`, `disp_C_dest[7:0]`, `disp_Z_dest[7:0]`, `disp_branch_pred`, `disp_ROB_index[6:0]` inputs: payload, stored verbatim.
- `disp_{opr1,opr2,prev}_rdy` input 1 each; `disp_{opr1,opr2,prev}_val` input 16 each: operand value if ready, else `val[6:0]` is the physical tag.
- `disp_{c,z}_rdy` input 1 each; `disp_{c,z}_val` input 8 each: flag value in bit 0 if ready, else the 8-bit flag tag.
- `wb_W` input 1, `wb_RR` input 7, `wb_D` input 16: register broadcast.
- `wb_C_W` input 1, `wb_C_RR` input 8, `wb_C` input 1: carry broadcast.
- `wb_Z_W` input 1, `wb_Z_RR` input 8, `wb_Z` input 1: zero broadcast.
- `rs_full` output 1: all DEPTH entries occupied.
- `rs_count` output $clog2(DEPTH)+1: number of occupied entries.
- `issue_valid` output 1: registered. Together with the `issue_*` outputs it forms the full `alu` input bundle: `valid, opcode, opr1, opr2, imm, carry, zero, neg_opr2, CZ_cond, dest, arch_dest, prev_dest, PC, C_dest, Z_dest, branch_pred, ROB_index_in`. Widths are identical to the `alu` inputs.

## Operation
- Entry state:
  - occupied bit;
  - 3 operand slots: ready bit plus 16-bit value/tag;
  - 2 flag slots: ready bit plus 8-bit value/tag;
  - payload;
  - age rank, 0 to DEPTH-1.
- Dispatch:
  - Accepted when `disp_valid && !rs_full && !flush`.
  - Writes the lowest-index free entry.
  - Rank = current `rs_count`, before this cycle's issue decrement is applied.
  - If dispatch occurs while `rs_full` is high, the request is dropped. No stall signal is returned; the dispatcher must honour `rs_full`.
- Dispatch bypass: a not-ready dispatched operand whose tag matches a same-cycle broadcast is stored as ready with the broadcast value. The same rule applies to flags.
- Wakeup:
  - Every occupied, not-ready operand slot compares its tag with `wb_RR` when `wb_W` is high. On a match it stores `wb_D` and sets its ready bit.
  - Carry slots compare against `wb_C_RR`/`wb_C_W`; zero slots compare against `wb_Z_RR`/`wb_Z_W`.
  - A match only makes the entry selectable in the following cycle.
- Select:
  - Eligible entry: occupied and all 5 ready bits set. The dispatcher sets the ready bit for unused sources.
  - Among eligible entries, pick the lowest rank. Rank values are unique by construction.
- Issue:
  - At the edge, the selected payload and values are loaded into the issue register, `issue_valid` is set to 1, and the entry is freed.
  - Every remaining entry with a higher rank decrements its rank by 1.
  - If nothing is eligible, `issue_valid` is cleared to 0 and the other issue outputs hold their previous values.
- Flush:
  - Clears all occupied bits and `issue_valid` at the edge.
  - Same-cycle dispatch and issue are suppressed.
- Counter: `rs_count` is updated as +1 on dispatch and -1 on issue. Simultaneous dispatch and issue leaves it unchanged.

## Timing
- Reset values:
  - all occupied bits 0;
  - `issue_valid` 0;
  - all `issue_*` outputs 0;
  - `rs_count` 0;
  - `rs_full` 0.
- Reset asserted mid-operation discards all entries immediately, with no clock required.
- Latency:
  - An entry that is ready at dispatch on edge t is selected in cycle t+1 and is on the `issue_*` outputs after edge t+1, i.e. minimum 2 cycles from `disp_valid` to `issue_valid`.
  - An entry woken by a broadcast in cycle t issues after edge t+1 at the earliest.
- Throughput: 1 dispatch and 1 issue per cycle, simultaneously allowed.
- `rs_full`/`rs_count` are combinational from registered occupancy. While full, a same-cycle issue does not admit that cycle's dispatch.
- Ranks stay dense: the occupied ranks are always exactly 0 to count-1.

## Test plan
- Basic issue and timing:
  - Dispatch ADD (opcode 0001) with opr1=0x0003 and opr2=0x0004, both ready, at cycle 0. Require `issue_valid`=1 at cycle 2 with `issue_opr1`=3 and `issue_opr2`=4, then `issue_valid`=0 at cycle 3.
  - Reset values: check every output reset value, including asserting `rst_n` low between clock edges.
- Wakeup:
  - Dispatch with opr2 not ready, tag 0x15. Require no issue.
  - Broadcast `wb_W`=1, `wb_RR`=0x15, `wb_D`=0xBEEF. Require issue after the next edge with `issue_opr2`=0xBEEF.
  - Same-cycle broadcast of tag 0x15 during dispatch: the entry issues after the next edge with `issue_opr2`=0xBEEF.
- Age ordering:
  - Dispatch A, B, C with all of them waiting on flag tag 0x22.
  - Broadcast `wb_C_W`=1, `wb_C_RR`=0x22, `wb_C`=1. Require issue order A, B, C on consecutive cycles, each with `issue_carry`=1.
- Full:
  - Fill DEPTH=8 entries with not-ready operations. Require `rs_full`=1 and `rs_count`=8.
  - A 9th dispatch is dropped, and `rs_count` stays 8.
  - Wake one entry: after it issues, `rs_full`=0.
  - Simultaneous dispatch and issue: `rs_count` unchanged.
- Flush:
  - With 5 entries occupied, an issue pending and a dispatch in the same cycle, assert `flush`.
  - Next cycle require `rs_count`=0, `issue_valid`=0, and no later issue of any flushed entry.

Source files
------------

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : Reservation station in front of the integer ALU pipe. Holds
//            dispatched ALU/branch/jump ops until all register operands and
//            flags are ready, snoops the register/flag writeback buses, and
//            issues the oldest ready op each cycle into a registered issue
//            bundle that feeds the combinational alu.
// Ports    : clk, rst_n (async, active-low), flush (sync kill)
//            disp_*  : dispatch request, payload and operand/flag slots
//            wb_*    : register, carry and zero writeback broadcasts
//            rs_full, rs_count : occupancy status
//            issue_* : registered alu input bundle
// Revision : 1.0  initial release
// ============================================================================
module alu_rs #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   disp_valid,
  input  logic [3:0]             disp_opcode,
  input  logic [15:0]            disp_imm,
  input  logic                   disp_neg_opr2,
  input  logic [1:0]             disp_CZ_cond,
  input  logic [6:0]             disp_dest,
  input  logic [2:0]             disp_arch_dest,
  input  logic [15:0]            disp_PC,
  input  logic [7:0]             disp_C_dest,
  input  logic [7:0]             disp_Z_dest,
  input  logic                   disp_branch_pred,
  input  logic [6:0]             disp_ROB_index,
  input  logic                   disp_opr1_rdy,
  input  logic                   disp_opr2_rdy,
  input  logic                   disp_prev_rdy,
  input  logic [15:0]            disp_opr1_val,
  input  logic [15:0]            disp_opr2_val,
  input  logic [15:0]            disp_prev_val,
  input  logic                   disp_c_rdy,
  input  logic                   disp_z_rdy,
  input  logic [7:0]             disp_c_val,
  input  logic [7:0]             disp_z_val,
  input  logic                   wb_W,
  input  logic [6:0]             wb_RR,
  input  logic [15:0]            wb_D,
  input  logic                   wb_C_W,
  input  logic [7:0]             wb_C_RR,
  input  logic                   wb_C,
  input  logic                   wb_Z_W,
  input  logic [7:0]             wb_Z_RR,
  input  logic                   wb_Z,
  output logic                   rs_full,
  output logic [$clog2(DEPTH):0] rs_count,
  output logic                   issue_valid,
  output logic [3:0]             issue_opcode,
  output logic [15:0]            issue_opr1,
  output logic [15:0]            issue_opr2,
  output logic [15:0]            issue_imm,
  output logic                   issue_carry,
  output logic                   issue_zero,
  output logic                   issue_neg_opr2,
  output logic [1:0]             issue_CZ_cond,
  output logic [6:0]             issue_dest,
  output logic [2:0]             issue_arch_dest,
  output logic [15:0]            issue_prev_dest,
  output logic [15:0]            issue_PC,
  output logic [7:0]             issue_C_dest,
  output logic [7:0]             issue_Z_dest,
  output logic                   issue_branch_pred,
  output logic [6:0]             issue_ROB_index_in
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Control state (reset)
  logic [DEPTH-1:0] occ;
  logic [IDX_W-1:0] rank [DEPTH];

  // Operand slots: index 0 = opr1, 1 = opr2, 2 = prev. Flags: 0 = carry, 1 = zero.
  // These are only meaningful while the entry is occupied, so they carry no reset.
  logic [2:0]  op_rdy [DEPTH];
  logic [15:0] op_val [DEPTH][3];
  logic [1:0]  fl_rdy [DEPTH];
  logic [7:0]  fl_val [DEPTH][2];

  logic [3:0]  e_opcode      [DEPTH];
  logic [15:0] e_imm         [DEPTH];
  logic        e_neg_opr2    [DEPTH];
  logic [1:0]  e_CZ_cond     [DEPTH];
  logic [6:0]  e_dest        [DEPTH];
  logic [2:0]  e_arch_dest   [DEPTH];
  logic [15:0] e_PC          [DEPTH];
  logic [7:0]  e_C_dest      [DEPTH];
  logic [7:0]  e_Z_dest      [DEPTH];
  logic        e_branch_pred [DEPTH];
  logic [6:0]  e_ROB_index   [DEPTH];

  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] elig;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_rank;
  logic [IDX_W-1:0] disp_rank;
  logic             sel_found;
  logic             disp_fire;
  logic             issue_fire;

  // Register-slot wakeup: returns {ready, value}. A not-ready slot holds its
  // physical tag in the low 7 bits.
  function automatic logic [16:0] wake_opr(input logic rdy, input logic [15:0] val,
                                           input logic w, input logic [6:0] rr,
                                           input logic [15:0] d);
    if (!rdy && w && (val[6:0] == rr)) return {1'b1, d};
    return {rdy, val};
  endfunction

  // Flag-slot wakeup: a woken flag keeps its value in bit 0.
  function automatic logic [8:0] wake_flag(input logic rdy, input logic [7:0] val,
                                           input logic w, input logic [7:0] rr,
                                           input logic d);
    if (!rdy && w && (val == rr)) return {1'b1, 7'd0, d};
    return {rdy, val};
  endfunction

  always_comb begin
    count     = '0;
    elig      = '0;
    free_idx  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    // Descending scan leaves the lowest free index as the final winner.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ[i]) free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      count   = count + CNT_W'(occ[i]);
      elig[i] = occ[i] && (&op_rdy[i]) && (&fl_rdy[i]);
      if (elig[i] && (!sel_found || (rank[i] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank[i];
      end
    end
  end

  assign rs_full    = (count == CNT_W'(DEPTH));
  assign rs_count   = count;
  assign disp_fire  = disp_valid && !rs_full && !flush;
  assign issue_fire = sel_found && !flush;
  // The new entry takes rank == count, then shares the decrement that every
  // entry above the issued one receives, keeping ranks dense.
  assign disp_rank  = count[IDX_W-1:0] - IDX_W'(issue_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) rank[i] <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && issue_fire) begin
          if (IDX_W'(i) == sel_idx) occ[i] <= 1'b0;
          else if (rank[i] > sel_rank) rank[i] <= rank[i] - IDX_W'(1);
        end
      end
      if (disp_fire) begin
        occ[free_idx]  <= 1'b1;
        rank[free_idx] <= disp_rank;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 3; s++) begin
        {op_rdy[i][s], op_val[i][s]} <= wake_opr(op_rdy[i][s], op_val[i][s], wb_W, wb_RR, wb_D);
      end
      {fl_rdy[i][0], fl_val[i][0]} <= wake_flag(fl_rdy[i][0], fl_val[i][0], wb_C_W, wb_C_RR, wb_C);
      {fl_rdy[i][1], fl_val[i][1]} <= wake_flag(fl_rdy[i][1], fl_val[i][1], wb_Z_W, wb_Z_RR, wb_Z);
    end
    if (disp_fire) begin
      // Dispatch bypass: a same-cycle broadcast is captured on entry.
      {op_rdy[free_idx][0], op_val[free_idx][0]} <= wake_opr(disp_opr1_rdy, disp_opr1_val, wb_W, wb_RR, wb_D);
      {op_rdy[free_idx][1], op_val[free_idx][1]} <= wake_opr(disp_opr2_rdy, disp_opr2_val, wb_W, wb_RR, wb_D);
      {op_rdy[free_idx][2], op_val[free_idx][2]} <= wake_opr(disp_prev_rdy, disp_prev_val, wb_W, wb_RR, wb_D);
      {fl_rdy[free_idx][0], fl_val[free_idx][0]} <= wake_flag(disp_c_rdy, disp_c_val, wb_C_W, wb_C_RR, wb_C);
      {fl_rdy[free_idx][1], fl_val[free_idx][1]} <= wake_flag(disp_z_rdy, disp_z_val, wb_Z_W, wb_Z_RR, wb_Z);
      e_opcode[free_idx]      <= disp_opcode;
      e_imm[free_idx]         <= disp_imm;
      e_neg_opr2[free_idx]    <= disp_neg_opr2;
      e_CZ_cond[free_idx]     <= disp_CZ_cond;
      e_dest[free_idx]        <= disp_dest;
      e_arch_dest[free_idx]   <= disp_arch_dest;
      e_PC[free_idx]          <= disp_PC;
      e_C_dest[free_idx]      <= disp_C_dest;
      e_Z_dest[free_idx]      <= disp_Z_dest;
      e_branch_pred[free_idx] <= disp_branch_pred;
      e_ROB_index[free_idx]   <= disp_ROB_index;
    end
  end

  // Issue register: payload holds its last value when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid        <= 1'b0;
      issue_opcode       <= '0;
      issue_opr1         <= '0;
      issue_opr2         <= '0;
      issue_imm          <= '0;
      issue_carry        <= 1'b0;
      issue_zero         <= 1'b0;
      issue_neg_opr2     <= 1'b0;
      issue_CZ_cond      <= '0;
      issue_dest         <= '0;
      issue_arch_dest    <= '0;
      issue_prev_dest    <= '0;
      issue_PC           <= '0;
      issue_C_dest       <= '0;
      issue_Z_dest       <= '0;
      issue_branch_pred  <= 1'b0;
      issue_ROB_index_in <= '0;
    end else if (issue_fire) begin
      issue_valid        <= 1'b1;
      issue_opcode       <= e_opcode[sel_idx];
      issue_opr1         <= op_val[sel_idx][0];
      issue_opr2         <= op_val[sel_idx][1];
      issue_imm          <= e_imm[sel_idx];
      issue_carry        <= fl_val[sel_idx][0][0];
      issue_zero         <= fl_val[sel_idx][1][0];
      issue_neg_opr2     <= e_neg_opr2[sel_idx];
      issue_CZ_cond      <= e_CZ_cond[sel_idx];
      issue_dest         <= e_dest[sel_idx];
      issue_arch_dest    <= e_arch_dest[sel_idx];
      issue_prev_dest    <= op_val[sel_idx][2];
      issue_PC           <= e_PC[sel_idx];
      issue_C_dest       <= e_C_dest[sel_idx];
      issue_Z_dest       <= e_Z_dest[sel_idx];
      issue_branch_pred  <= e_branch_pred[sel_idx];
      issue_ROB_index_in <= e_ROB_index[sel_idx];
    end else begin
      // Covers both flush and an empty select.
      issue_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Purpose  : Directed self-checking bench for alu_rs (DEPTH = 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst_n, flush, disp_valid;
  logic [3:0]  disp_opcode;
  logic [15:0] disp_imm, disp_PC, disp_opr1_val, disp_opr2_val, disp_prev_val, wb_D;
  logic        disp_neg_opr2, disp_branch_pred;
  logic [1:0]  disp_CZ_cond;
  logic [6:0]  disp_dest, disp_ROB_index, wb_RR;
  logic [2:0]  disp_arch_dest;
  logic [7:0]  disp_C_dest, disp_Z_dest, disp_c_val, disp_z_val, wb_C_RR, wb_Z_RR;
  logic        disp_opr1_rdy, disp_opr2_rdy, disp_prev_rdy, disp_c_rdy, disp_z_rdy;
  logic        wb_W, wb_C_W, wb_C, wb_Z_W, wb_Z;
  logic        rs_full;
  logic [3:0]  rs_count;
  logic        issue_valid, issue_carry, issue_zero, issue_neg_opr2, issue_branch_pred;
  logic [3:0]  issue_opcode;
  logic [15:0] issue_opr1, issue_opr2, issue_imm, issue_prev_dest, issue_PC;
  logic [1:0]  issue_CZ_cond;
  logic [6:0]  issue_dest, issue_ROB_index_in;
  logic [2:0]  issue_arch_dest;
  logic [7:0]  issue_C_dest, issue_Z_dest;

  int n_cmp = 0;
  int n_bad = 0;

  alu_rs #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid),
    .disp_opcode(disp_opcode), .disp_imm(disp_imm), .disp_neg_opr2(disp_neg_opr2),
    .disp_CZ_cond(disp_CZ_cond), .disp_dest(disp_dest), .disp_arch_dest(disp_arch_dest),
    .disp_PC(disp_PC), .disp_C_dest(disp_C_dest), .disp_Z_dest(disp_Z_dest),
    .disp_branch_pred(disp_branch_pred), .disp_ROB_index(disp_ROB_index),
    .disp_opr1_rdy(disp_opr1_rdy), .disp_opr2_rdy(disp_opr2_rdy), .disp_prev_rdy(disp_prev_rdy),
    .disp_opr1_val(disp_opr1_val), .disp_opr2_val(disp_opr2_val), .disp_prev_val(disp_prev_val),
    .disp_c_rdy(disp_c_rdy), .disp_z_rdy(disp_z_rdy), .disp_c_val(disp_c_val), .disp_z_val(disp_z_val),
    .wb_W(wb_W), .wb_RR(wb_RR), .wb_D(wb_D),
    .wb_C_W(wb_C_W), .wb_C_RR(wb_C_RR), .wb_C(wb_C),
    .wb_Z_W(wb_Z_W), .wb_Z_RR(wb_Z_RR), .wb_Z(wb_Z),
    .rs_full(rs_full), .rs_count(rs_count), .issue_valid(issue_valid),
    .issue_opcode(issue_opcode), .issue_opr1(issue_opr1), .issue_opr2(issue_opr2),
    .issue_imm(issue_imm), .issue_carry(issue_carry), .issue_zero(issue_zero),
    .issue_neg_opr2(issue_neg_opr2), .issue_CZ_cond(issue_CZ_cond), .issue_dest(issue_dest),
    .issue_arch_dest(issue_arch_dest), .issue_prev_dest(issue_prev_dest), .issue_PC(issue_PC),
    .issue_C_dest(issue_C_dest), .issue_Z_dest(issue_Z_dest),
    .issue_branch_pred(issue_branch_pred), .issue_ROB_index_in(issue_ROB_index_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_imm = '0; disp_PC = '0;
    disp_neg_opr2 = 1'b0; disp_branch_pred = 1'b0; disp_CZ_cond = '0; disp_dest = '0;
    disp_ROB_index = '0; disp_arch_dest = '0; disp_C_dest = '0; disp_Z_dest = '0;
    disp_opr1_rdy = 1'b0; disp_opr2_rdy = 1'b0; disp_prev_rdy = 1'b0; disp_c_rdy = 1'b0;
    disp_z_rdy = 1'b0; disp_opr1_val = '0; disp_opr2_val = '0; disp_prev_val = '0;
    disp_c_val = '0; disp_z_val = '0;
    wb_W = 1'b0; wb_RR = '0; wb_D = '0; wb_C_W = 1'b0; wb_C_RR = '0; wb_C = 1'b0;
    wb_Z_W = 1'b0; wb_Z_RR = '0; wb_Z = 1'b0;
  endtask

  task automatic drive_disp(input logic [15:0] pc, input logic r1, input logic [15:0] v1,
                            input logic r2, input logic [15:0] v2,
                            input logic cr, input logic [7:0] cv);
    disp_valid = 1'b1; disp_opcode = 4'h1; disp_PC = pc; disp_imm = 16'h0;
    disp_opr1_rdy = r1; disp_opr1_val = v1; disp_opr2_rdy = r2; disp_opr2_val = v2;
    disp_prev_rdy = 1'b1; disp_prev_val = 16'h0;
    disp_c_rdy = cr; disp_c_val = cv; disp_z_rdy = 1'b1; disp_z_val = 8'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    n_cmp++; if (rs_count !== 4'd0) begin n_bad++; $display("FAIL reset_rs_count: got %0d want 0", rs_count); end
    n_cmp++; if (rs_full !== 1'b0) begin n_bad++; $display("FAIL reset_rs_full: got %b want 0", rs_full); end
    n_cmp++;
    if ({issue_opcode, issue_opr1, issue_opr2, issue_imm, issue_carry, issue_zero, issue_neg_opr2,
         issue_CZ_cond, issue_dest, issue_arch_dest, issue_prev_dest, issue_PC, issue_C_dest,
         issue_Z_dest, issue_branch_pred, issue_ROB_index_in} !== '0) begin
      n_bad++; $display("FAIL reset_issue_bundle: got opcode=%h opr1=%h opr2=%h PC=%h want all zero",
                        issue_opcode, issue_opr1, issue_opr2, issue_PC);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    drive_disp(16'h0010, 1'b1, 16'h0003, 1'b1, 16'h0004, 1'b1, 8'h00);
    disp_imm = 16'h00AB; disp_ROB_index = 7'h2A;
    tick();
    clear_inputs();
    n_cmp++; if (rs_count !== 4'd1) begin n_bad++; $display("FAIL basic_count_after_disp: got %0d want 1", rs_count); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_issue: got %b want 0", issue_valid); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL basic_issue_valid: got %b want 1", issue_valid); end
    n_cmp++; if (issue_opr1 !== 16'h0003 || issue_opr2 !== 16'h0004) begin n_bad++; $display("FAIL basic_operands: got %h/%h want 0003/0004", issue_opr1, issue_opr2); end
    n_cmp++; if (issue_opcode !== 4'h1 || issue_imm !== 16'h00AB || issue_ROB_index_in !== 7'h2A) begin n_bad++; $display("FAIL basic_payload: got op=%h imm=%h rob=%h want 1/00ab/2a", issue_opcode, issue_imm, issue_ROB_index_in); end
    n_cmp++; if (rs_count !== 4'd0) begin n_bad++; $display("FAIL basic_count_after_issue: got %0d want 0", rs_count); end
    tick();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", issue_valid); end
  endtask

  task automatic test_wakeup;
    drive_disp(16'h0020, 1'b1, 16'h0001, 1'b0, 16'h0015, 1'b1, 8'h00);
    tick();
    clear_inputs();
    tick(); tick();
    n_cmp++; if (issue_valid !== 1'b0 || rs_count !== 4'd1) begin n_bad++; $display("FAIL wakeup_waiting: got valid=%b count=%0d want 0/1", issue_valid, rs_count); end
    wb_W = 1'b1; wb_RR = 7'h15; wb_D = 16'hBEEF;
    tick();
    clear_inputs();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL wakeup_same_edge_issue: got %b want 0", issue_valid); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_opr2 !== 16'hBEEF || issue_opr1 !== 16'h0001) begin n_bad++; $display("FAIL wakeup_issue: got valid=%b opr1=%h opr2=%h want 1/0001/beef", issue_valid, issue_opr1, issue_opr2); end
  endtask

  task automatic test_bypass;
    drive_disp(16'h0030, 1'b1, 16'h0002, 1'b0, 16'h0015, 1'b1, 8'h00);
    wb_W = 1'b1; wb_RR = 7'h15; wb_D = 16'hBEEF;
    tick();
    clear_inputs();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL bypass_early: got %b want 0", issue_valid); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_opr2 !== 16'hBEEF || issue_PC !== 16'h0030) begin n_bad++; $display("FAIL bypass_issue: got valid=%b opr2=%h PC=%h want 1/beef/0030", issue_valid, issue_opr2, issue_PC); end
    tick();
  endtask

  task automatic test_age_order;
    drive_disp(16'h0100, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h22); tick();
    drive_disp(16'h0200, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h22); tick();
    drive_disp(16'h0300, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h22); tick();
    clear_inputs();
    n_cmp++; if (rs_count !== 4'd3 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL age_waiting: got count=%0d valid=%b want 3/0", rs_count, issue_valid); end
    wb_C_W = 1'b1; wb_C_RR = 8'h22; wb_C = 1'b1;
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 16'h0100 || issue_carry !== 1'b1) begin n_bad++; $display("FAIL age_first: got valid=%b PC=%h carry=%b want 1/0100/1", issue_valid, issue_PC, issue_carry); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 16'h0200 || issue_carry !== 1'b1) begin n_bad++; $display("FAIL age_second: got valid=%b PC=%h carry=%b want 1/0200/1", issue_valid, issue_PC, issue_carry); end
    tick();
    n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 16'h0300 || issue_carry !== 1'b1) begin n_bad++; $display("FAIL age_third: got valid=%b PC=%h carry=%b want 1/0300/1", issue_valid, issue_PC, issue_carry); end
    tick();
    n_cmp++; if (issue_valid !== 1'b0 || rs_count !== 4'd0) begin n_bad++; $display("FAIL age_drain: got valid=%b count=%0d want 0/0", issue_valid, rs_count); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) begin
      drive_disp(16'(i), 1'b0, 16'(16'h0040 + i), 1'b1, 16'h0000, 1'b1, 8'h00);
      tick();
    end
    clear_inputs();
    n_cmp++; if (rs_full !== 1'b1 || rs_count !== 4'd8) begin n_bad++; $display("FAIL full_status: got full=%b count=%0d want 1/8", rs_full, rs_count); end
    // 9th dispatch (ready) held for two cycles while tag 0x43 wakes entry 3.
    drive_disp(16'h0099, 1'b1, 16'h0009, 1'b1, 16'h0009, 1'b1, 8'h00);
    wb_W = 1'b1; wb_RR = 7'h43; wb_D = 16'h1234;
    tick();
    wb_W = 1'b0;
    n_cmp++; if (rs_count !== 4'd8 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL full_drop: got count=%0d valid=%b want 8/0", rs_count, issue_valid); end
    tick();
    clear_inputs();
    n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 16'h0003 || issue_opr1 !== 16'h1234) begin n_bad++; $display("FAIL full_wake_issue: got valid=%b PC=%h opr1=%h want 1/0003/1234", issue_valid, issue_PC, issue_opr1); end
    n_cmp++; if (rs_full !== 1'b0 || rs_count !== 4'd7) begin n_bad++; $display("FAIL full_after_issue: got full=%b count=%0d want 0/7", rs_full, rs_count); end
    tick();
    n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL full_dropped_issued: got valid=%b PC=%h want 0", issue_valid, issue_PC); end
    wb_W = 1'b1; wb_RR = 7'h44; wb_D = 16'h4444;
    tick();
    clear_inputs();
    drive_disp(16'h0060, 1'b0, 16'h0060, 1'b1, 16'h0000, 1'b1, 8'h00);
    tick();
    clear_inputs();
    n_cmp++; if (issue_valid !== 1'b1 || issue_PC !== 16'h0004 || rs_count !== 4'd7) begin n_bad++; $display("FAIL full_simul_disp_issue: got valid=%b PC=%h count=%0d want 1/0004/7", issue_valid, issue_PC, rs_count); end
  endtask

  task automatic test_flush;
    int seen;
    flush = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_clear: got count=%0d valid=%b want 0/0", rs_count, issue_valid); end
    for (int i = 0; i < 4; i++) begin
      drive_disp(16'(16'h0050 + i), 1'b0, 16'(16'h0050 + i), 1'b1, 16'h0000, 1'b1, 8'h00);
      tick();
    end
    drive_disp(16'h00AA, 1'b1, 16'h0001, 1'b1, 16'h0001, 1'b1, 8'h00);
    tick();
    n_cmp++; if (rs_count !== 4'd5) begin n_bad++; $display("FAIL flush_setup_count: got %0d want 5", rs_count); end
    drive_disp(16'h00BB, 1'b1, 16'h0002, 1'b1, 16'h0002, 1'b1, 8'h00);
    flush = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (rs_count !== 4'd0 || issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: got count=%0d valid=%b want 0/0", rs_count, issue_valid); end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      wb_W = 1'b1; wb_RR = 7'(7'h50 + k); wb_D = 16'h7777;
      tick();
      if (issue_valid === 1'b1) seen++;
    end
    clear_inputs();
    tick();
    if (issue_valid === 1'b1) seen++;
    n_cmp++; if (seen != 0 || rs_count !== 4'd0) begin n_bad++; $display("FAIL flush_no_late_issue: got issues=%0d count=%0d want 0/0", seen, rs_count); end
  endtask

  task automatic test_async_reset;
    drive_disp(16'h0077, 1'b1, 16'h5555, 1'b1, 16'h6666, 1'b1, 8'h00);
    tick();
    drive_disp(16'h0078, 1'b0, 16'h0010, 1'b1, 16'h0000, 1'b1, 8'h00);
    tick();
    clear_inputs();
    n_cmp++; if (issue_valid !== 1'b1 || rs_count !== 4'd1) begin n_bad++; $display("FAIL async_setup: got valid=%b count=%0d want 1/1", issue_valid, rs_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (issue_valid !== 1'b0 || rs_count !== 4'd0 || rs_full !== 1'b0) begin n_bad++; $display("FAIL async_reset_ctrl: got valid=%b count=%0d full=%b want 0/0/0", issue_valid, rs_count, rs_full); end
    n_cmp++; if (issue_opr1 !== 16'h0 || issue_opr2 !== 16'h0 || issue_PC !== 16'h0) begin n_bad++; $display("FAIL async_reset_payload: got opr1=%h opr2=%h PC=%h want 0/0/0", issue_opr1, issue_opr2, issue_PC); end
    #1 rst_n = 1'b1;
    wb_W = 1'b1; wb_RR = 7'h10; wb_D = 16'h1111;
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (issue_valid !== 1'b0 || rs_count !== 4'd0) begin n_bad++; $display("FAIL async_reset_discard: got valid=%b count=%0d want 0/0", issue_valid, rs_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_age_order();
    test_full();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
